// File: rtl/tia_horizontal_sync_counter.sv
// Horizontal sync counter: divides the colour clock into two phase strobes, steps a 57-state
// line counter and decodes HSYNC/HBLANK/burst/centre/line-start. Optional: TIA_HMOVE_BLANK_EN.
module tia_horizontal_sync_counter #(
   parameter int unsigned LINE_STEPS = 57,
   parameter int unsigned PHASE_DIV  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rsyn_gated,
   input  logic       hmove,
   output logic       h_phi1,
   output logic       h_phi2,
   output logic [5:0] hcount,
   output logic       hsync,
   output logic       hblank,
   output logic       cburst,
   output logic       center,
   output logic       line_start
);

   localparam int unsigned DivW = $clog2(PHASE_DIV);

   localparam logic [5:0] HsyncFirst  = 6'd4;
   localparam logic [5:0] HsyncLast   = 6'd7;
   localparam logic [5:0] BurstFirst  = 6'd8;
   localparam logic [5:0] BurstLast   = 6'd11;
   localparam logic [5:0] BlankLast   = 6'd16;
   localparam logic [5:0] BlankLastHm = 6'd18;
   localparam logic [5:0] CenterIdx   = 6'd36;
   localparam logic [5:0] LastIdx     = 6'(LINE_STEPS - 1);

   logic [DivW-1:0] r_div;
   logic [5:0]      r_hcount;
   logic            r_h_phi1;
   logic            r_h_phi2;
   logic            r_hsync;
   logic            r_hblank;
   logic            r_cburst;
   logic            r_center;
   logic            r_line_start;
   logic            r_rsyn_q;

   logic [DivW-1:0] w_div_nxt;
   logic            w_adv;
   logic            w_wrap;
   logic [5:0]      w_hc_nxt;
   logic [5:0]      w_blank_last;
   logic            w_ls_nxt;

   always_comb begin
      w_div_nxt = '0;
      if (r_div != DivW'(PHASE_DIV - 1)) begin
         w_div_nxt = r_div + 1'b1;
      end
      w_adv    = r_h_phi2;
      w_wrap   = w_adv && (r_hcount == LastIdx);
      w_hc_nxt = r_hcount;
      if (w_wrap) begin
         w_hc_nxt = '0;
      end else if (w_adv) begin
         w_hc_nxt = r_hcount + 6'd1;
      end
      // Only the first edge of a held restart request counts as a line start.
      w_ls_nxt = rsyn_gated ? !r_rsyn_q : w_wrap;
   end

`ifdef TIA_HMOVE_BLANK_EN
   logic r_hmove_latch;
   logic r_blank_ext;

   // The latch armed during one line stretches the blank of the line that follows it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hmove_latch <= 1'b0;
         r_blank_ext   <= 1'b0;
      end else if (w_ls_nxt) begin
         r_blank_ext   <= r_hmove_latch;
         r_hmove_latch <= hmove;
      end else if (hmove) begin
         r_hmove_latch <= 1'b1;
      end
   end

   assign w_blank_last = r_blank_ext ? BlankLastHm : BlankLast;
`else
   logic w_unused_hmove;
   assign w_unused_hmove = hmove;
   assign w_blank_last   = BlankLast;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div        <= '0;
         r_hcount     <= '0;
         r_h_phi1     <= 1'b0;
         r_h_phi2     <= 1'b0;
         r_hsync      <= 1'b0;
         r_hblank     <= 1'b1;
         r_cburst     <= 1'b0;
         r_center     <= 1'b0;
         r_line_start <= 1'b0;
         r_rsyn_q     <= 1'b0;
      end else begin
         r_rsyn_q     <= rsyn_gated;
         r_line_start <= w_ls_nxt;
         if (rsyn_gated) begin
            r_div    <= '0;
            r_hcount <= '0;
            r_h_phi1 <= 1'b0;
            r_h_phi2 <= 1'b0;
            r_hsync  <= 1'b0;
            r_hblank <= 1'b1;
            r_cburst <= 1'b0;
            r_center <= 1'b0;
         end else begin
            r_div    <= w_div_nxt;
            r_h_phi1 <= (w_div_nxt == DivW'(1));
            r_h_phi2 <= (w_div_nxt == DivW'(PHASE_DIV - 1));
            r_hcount <= w_hc_nxt;
            r_hsync  <= (w_hc_nxt >= HsyncFirst) && (w_hc_nxt <= HsyncLast);
            r_cburst <= (w_hc_nxt >= BurstFirst) && (w_hc_nxt <= BurstLast);
            r_hblank <= (w_hc_nxt <= w_blank_last);
            r_center <= w_adv && (w_hc_nxt == CenterIdx);
         end
      end
   end

   assign h_phi1     = r_h_phi1;
   assign h_phi2     = r_h_phi2;
   assign hcount     = r_hcount;
   assign hsync      = r_hsync;
   assign hblank     = r_hblank;
   assign cburst     = r_cburst;
   assign center     = r_center;
   assign line_start = r_line_start;

endmodule
